// File: rtl/engine_arbiter_pkg.sv
// Shared types and defaults for the engine arbiter slice.
package engine_arbiter_pkg;

    // Scheduler states; encodings are fixed so waveforms stay comparable across builds.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

    localparam int unsigned DefWidth   = 32;
    localparam int unsigned DefTimeout = 1024;

    // Bits needed to index n items; never zero so single-entry vectors stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/engine_arbiter_rr.sv
// Combinational rotate-priority arbiter: first request at or above ptr, with wrap.
module rr_arbiter
    import engine_arbiter_pkg::*;
#(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    int unsigned     pos;
    logic [IdxW-1:0] pos_idx;

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            pos     = (32'(ptr_i) + i) % NumReq;
            pos_idx = IdxW'(pos);
            if (!any_o && req_i[pos_idx]) begin
                gnt_o[pos_idx] = 1'b1;
                idx_o          = pos_idx;
                any_o          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/engine_arbiter.sv
// Round-robin scheduler sharing one multiply-compare engine between NUM_REQ requesters.
module engine_arbiter
    import engine_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_c_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    input  logic [NUM_REQ-1:0]       rsp_ready_i,
    output logic [WIDTH-1:0]         rsp_data_o,
    output logic                     rsp_flag_o,
    output logic                     rsp_err_o,
    output logic                     eng_start_o,
    output logic                     eng_abort_o,
    output logic [WIDTH-1:0]         eng_a_o,
    output logic [WIDTH-1:0]         eng_b_o,
    output logic [WIDTH-1:0]         eng_c_o,
    input  logic                     eng_done_i,
    input  logic [WIDTH-1:0]         eng_out_i,
    input  logic                     eng_flag_i
);

    localparam int unsigned IdxW = idx_width(NUM_REQ);
    localparam int unsigned CntW = idx_width(TIMEOUT);

    arb_state_e         state_q, state_d;
    logic [IdxW-1:0]    ptr_q, ptr_d, owner_q, owner_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   eng_a_q, eng_a_d, eng_b_q, eng_b_d, eng_c_q, eng_c_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_flag_q, rsp_flag_d, rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IdxW-1:0]    gnt_idx;
    logic               gnt_any;
    logic [WIDTH-1:0]   sel_a, sel_b, sel_c;

    rr_arbiter #(
        .NumReq (NUM_REQ),
        .IdxW   (IdxW)
    ) u_rr (
        .req_i  (req_valid_i),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx),
        .any_o  (gnt_any)
    );

    // Mux the granted requester's operands with constant slice bases.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a_i[i*WIDTH +: WIDTH];
                sel_b = req_b_i[i*WIDTH +: WIDTH];
                sel_c = req_c_i[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and handshake/strobe outputs.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        eng_a_d     = eng_a_q;
        eng_b_d     = eng_b_q;
        eng_c_d     = eng_c_q;
        rsp_data_d  = rsp_data_q;
        rsp_flag_d  = rsp_flag_q;
        rsp_err_d   = rsp_err_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        eng_start_o = 1'b0;
        eng_abort_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    req_ready_o = gnt;
                    owner_d     = gnt_idx;
                    eng_a_d     = sel_a;
                    eng_b_d     = sel_b;
                    eng_c_d     = sel_c;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                eng_start_o = 1'b1;
                cnt_d       = '0;
                state_d     = StWait;
            end
            StWait: begin
                // Completion takes priority over a coincident watchdog expiry.
                if (eng_done_i) begin
                    rsp_data_d = eng_out_i;
                    rsp_flag_d = eng_flag_i;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    eng_abort_o = 1'b1;
                    rsp_data_d  = '0;
                    rsp_flag_d  = 1'b0;
                    rsp_err_d   = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                rsp_valid_o[owner_q] = 1'b1;
                if (rsp_ready_i[owner_q]) begin
                    ptr_d   = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + IdxW'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset drops any in-flight job silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            eng_a_q    <= '0;
            eng_b_q    <= '0;
            eng_c_q    <= '0;
            rsp_data_q <= '0;
            rsp_flag_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            eng_a_q    <= eng_a_d;
            eng_b_q    <= eng_b_d;
            eng_c_q    <= eng_c_d;
            rsp_data_q <= rsp_data_d;
            rsp_flag_q <= rsp_flag_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign eng_a_o    = eng_a_q;
    assign eng_b_o    = eng_b_q;
    assign eng_c_o    = eng_c_q;
    assign rsp_data_o = rsp_data_q;
    assign rsp_flag_o = rsp_flag_q;
    assign rsp_err_o  = rsp_err_q;

endmodule

// File: tb/tb_engine_arbiter.sv
// Directed plus randomized bench for engine_arbiter with a 5-cycle engine model.
module tb_engine_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_a, req_b, req_c;
    logic [W-1:0]   rsp_data, eng_a, eng_b, eng_c;
    logic           rsp_flag, rsp_err, eng_start, eng_abort;
    logic           eng_done = 1'b0;
    logic [W-1:0]   eng_out  = '0;
    logic           eng_flag = 1'b0;

    int total = 0;
    int bad   = 0;
    int ptr_m = 0;
    int last_g = -1;
    int grants[$];
    int cd = 0;
    bit eng_en = 1'b1;

    engine_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_c_i     (req_c),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_flag_o  (rsp_flag),
        .rsp_err_o   (rsp_err),
        .eng_start_o (eng_start),
        .eng_abort_o (eng_abort),
        .eng_a_o     (eng_a),
        .eng_b_o     (eng_b),
        .eng_c_o     (eng_c),
        .eng_done_i  (eng_done),
        .eng_out_i   (eng_out),
        .eng_flag_i  (eng_flag)
    );

    // Engine: done pulses 5 cycles after the start cycle; keeps running across DUT reset.
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (cd != 0) begin
            cd = cd - 1;
            if (cd == 0) eng_done = eng_en;
        end
        if (eng_start === 1'b1) begin
            cd       = 5;
            eng_out  = eng_a * eng_b;
            eng_flag = (eng_out > eng_c);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            int j = (p + i) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] one = 1;
        return (g < 0) ? '0 : (one << g);
    endfunction

    task automatic set_ops(input int i);
        req_a[i*W +: W] = $urandom_range(0, 1000);
        req_b[i*W +: W] = $urandom_range(0, 1000);
        req_c[i*W +: W] = $urandom_range(0, 500000);
    endtask

    // One complete job starting at an IDLE negedge: grant, issue, wait, response, release.
    task automatic serve(input bit keep, input int hold, input bit exp_to);
        int g, n, aborts, abort_n, vstart, viol;
        logic [W-1:0] a, b, c, p, d0;
        g = pick(req_valid, ptr_m);
        rsp_ready = (hold > 0) ? ~onehot(g) : '1;
        #1 check("grant", 64'(req_ready), 64'(onehot(g)));
        if (g < 0) return;
        a = req_a[g*W +: W];
        b = req_b[g*W +: W];
        c = req_c[g*W +: W];
        last_g = g;
        grants.push_back(g);
        @(negedge clk);
        if (keep) set_ops(g);
        else req_valid[g] = 1'b0;
        #1 check("start", 64'(eng_start), 64'd1);
        check("eng_ab", {eng_a, eng_b}, {a, b});
        check("eng_c", 64'(eng_c), 64'(c));
        n = 0; aborts = 0; abort_n = 0; vstart = 0;
        while (rsp_valid == '0 && n < 60) begin
            @(negedge clk);
            #1 n++;
            if (eng_start !== 1'b0) vstart++;
            if (eng_abort === 1'b1) begin
                aborts++;
                abort_n = n;
            end
        end
        check("latency", 64'(n), exp_to ? 64'd17 : 64'd6);
        check("aborts", 64'(aborts), exp_to ? 64'd1 : 64'd0);
        if (exp_to) check("abort_cycle", 64'(abort_n), 64'd16);
        check("no_restart", 64'(vstart), 64'd0);
        p = a * b;
        check("rsp_valid", 64'(rsp_valid), 64'(onehot(g)));
        if (exp_to) check("rsp", {rsp_data, rsp_flag, rsp_err}, {32'd0, 1'b0, 1'b1});
        else        check("rsp", {rsp_data, rsp_flag, rsp_err}, {p, p > c, 1'b0});
        d0 = rsp_data;
        viol = 0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== onehot(g) || rsp_data !== d0 || req_ready !== '0 ||
                eng_start !== 1'b0) viol++;
        end
        check("backpressure", 64'(viol), 64'd0);
        rsp_ready = '1;
        ptr_m = (g + 1) % N;
        @(negedge clk);
        #1 check("rsp_done", 64'(rsp_valid), 64'd0);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] newv;
        int viol;
        rst_n = 1'b0; req_valid = '0; rsp_ready = '1;
        req_a = '0; req_b = '0; req_c = '0;
        #1;
        check("rst_strobes", {req_ready, rsp_valid, eng_start, eng_abort, rsp_flag, rsp_err}, 64'd0);
        check("rst_data", {rsp_data, eng_a}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single job from requester 0.
        req_a[0 +: W] = 3; req_b[0 +: W] = 7; req_c[0 +: W] = 20;
        req_valid = 4'b0001;
        serve(1'b0, 0, 1'b0);
        check("single_data", {rsp_data, rsp_flag}, {32'd21, 1'b1});

        // Fairness with everyone valid continuously.
        apply_reset();
        for (int i = 0; i < N; i++) set_ops(i);
        req_valid = '1;
        grants.delete();
        for (int k = 0; k < 5; k++) serve(1'b1, 0, 1'b0);
        for (int k = 0; k < 5; k++) check("fair_order", 64'(grants[k]), 64'(k % N));
        while (req_valid != '0) serve(1'b0, 0, 1'b0);

        // Pointer wrap after requester 3.
        set_ops(3); req_valid = 4'b1000;
        serve(1'b0, 0, 1'b0);
        set_ops(0); set_ops(2); req_valid = 4'b0101;
        serve(1'b0, 0, 1'b0);
        check("wrap_first", 64'(last_g), 64'd0);
        serve(1'b0, 0, 1'b0);

        // Watchdog timeout with a silent engine.
        eng_en = 1'b0;
        set_ops(1); req_valid = 4'b0010;
        serve(1'b0, 0, 1'b1);
        eng_en = 1'b1;

        // Response backpressure with other requesters pending.
        for (int i = 0; i < N; i++) set_ops(i);
        req_valid = '1;
        serve(1'b0, 10, 1'b0);
        while (req_valid != '0) serve(1'b0, 0, 1'b0);

        // Randomized traffic against the rotation model.
        for (int it = 0; it < 40; it++) begin
            newv = N'($urandom) & ~req_valid;
            for (int i = 0; i < N; i++) if (newv[i]) set_ops(i);
            req_valid = req_valid | newv;
            if (req_valid == '0) begin
                #1 check("idle_noreq", 64'(req_ready), 64'd0);
                @(negedge clk);
            end else begin
                serve(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
            end
        end
        while (req_valid != '0) serve(1'b0, 0, 1'b0);

        // Asynchronous reset while waiting on the engine.
        @(negedge clk);
        set_ops(2); req_valid = 4'b0100;
        #1 check("rst_job_grant", 64'(req_ready), 64'(onehot(pick(req_valid, ptr_m))));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_strobes",
                 {req_ready, rsp_valid, eng_start, eng_abort, rsp_flag, rsp_err}, 64'd0);
        check("async_rst_data", {eng_a, eng_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        viol  = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== '0 || eng_start !== 1'b0 || req_ready !== '0) viol++;
        end
        check("stale_done_ignored", 64'(viol), 64'd0);
        @(negedge clk);
        for (int i = 0; i < N; i++) set_ops(i);
        req_valid = '1;
        serve(1'b0, 0, 1'b0);
        check("post_rst_first", 64'(last_g), 64'd0);
        while (req_valid != '0) serve(1'b0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
